// File: rtl/int_ctrl_pri_pkg.sv
// int_ctrl_pri_pkg
// Shared definitions for the prioritised interrupt controller:
//   - word addresses of the eight Wishbone registers
//   - CLAIM_NONE, returned by a CLAIM read that yields no source
//   - claim/complete state encoding
package int_ctrl_pri_pkg;

  localparam logic [2:0] ADDR_MER      = 3'd0;
  localparam logic [2:0] ADDR_IER      = 3'd1;
  localparam logic [2:0] ADDR_ITR      = 3'd2;
  localparam logic [2:0] ADDR_ICR      = 3'd3;
  localparam logic [2:0] ADDR_IPR      = 3'd4;
  localparam logic [2:0] ADDR_CLAIM    = 3'd5;
  localparam logic [2:0] ADDR_COMPLETE = 3'd6;
  localparam logic [2:0] ADDR_ISR      = 3'd7;

  localparam logic [31:0] CLAIM_NONE = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/int_pri_enc.sv
// int_pri_enc
// Find-lowest-set-bit encoder. Index 0 has the highest priority.
// Ports:
//   req   in  N   request vector
//   idx   out 5   index of the lowest set bit (0 when none set)
//   valid out 1   at least one request bit set
module int_pri_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [4:0]   idx,
  output logic         valid
);

  // Scan from the top down so the last assignment is the lowest set bit.
  always_comb begin
    idx   = 5'd0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = 5'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl_pri.sv
// int_ctrl_pri
// Prioritised, vectored Wishbone interrupt controller with claim/complete.
// Optional build macro: INT_CTRL_SYNC_EN adds a two-flop synchroniser on
// every int_i bit (two extra cycles of int_i-to-ipr latency).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   sa_dat_i/sel/addr/stb/we   Wishbone slave inputs (sel ignored)
//   sa_dat_o, sa_ack_o    registered read data and acknowledge
//   sa_err_o, sa_rty_o    tied 0
//   int_i                 raw active-high interrupt lines
//   int_o                 interrupt request to the CPU
//   int_id_o              lowest enabled pending source index (0 if none)
//   dbg_state             claim FSM state (1 = ACTIVE, a source in service)
// Bus handshake: an access is taken in the cycle where sa_stb_i is high and
// sa_ack_o is low; all register side effects happen only in that cycle and
// sa_ack_o is raised for exactly the following cycle together with read data.
module int_ctrl_pri
  import int_ctrl_pri_pkg::*;
#(
  parameter int INT_NUM = 8,
  parameter int Dw      = 32,
  parameter int Aw      = 3,
  parameter int SELw    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [Dw-1:0]      sa_dat_i,
  input  logic [SELw-1:0]    sa_sel_i,
  input  logic [Aw-1:0]      sa_addr_i,
  input  logic               sa_stb_i,
  input  logic               sa_we_i,
  output logic [Dw-1:0]      sa_dat_o,
  output logic               sa_ack_o,
  output logic               sa_err_o,
  output logic               sa_rty_o,
  input  logic [INT_NUM-1:0] int_i,
  output logic               int_o,
  output logic [4:0]         int_id_o,
  output logic               dbg_state
);

  state_t             state_q, state_d;
  logic [1:0]         mer;
  logic [INT_NUM-1:0] ier, itr, ipr, ipr_d;
  logic [INT_NUM-1:0] int_src, int_q, int_prev;
  logic [4:0]         active_id;
  logic [Dw-1:0]      rd_data;

  // Byte selects are ignored: every access is a full word.
  logic unused_bits;
  assign unused_bits = ^sa_sel_i;

  assign sa_err_o = 1'b0;
  assign sa_rty_o = 1'b0;

  logic [2:0] addr;
  assign addr = sa_addr_i[2:0];

  logic access, wr, rd;
  assign access = sa_stb_i && !sa_ack_o;
  assign wr     = access && sa_we_i;
  assign rd     = access && !sa_we_i;

`ifdef INT_CTRL_SYNC_EN
  logic [INT_NUM-1:0] sync1, sync2;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= int_i;
      sync2 <= sync1;
    end
  end
  assign int_src = sync2;
`else
  assign int_src = int_i;
`endif

  // Priority encoder over enabled pending sources.
  logic [INT_NUM-1:0] pend;
  logic [4:0]         pend_id;
  logic               pend_valid;
  assign pend = ipr & ier;

  int_pri_enc #(.N(INT_NUM)) u_enc (
    .req   (pend),
    .idx   (pend_id),
    .valid (pend_valid)
  );

  logic claim_take, complete_hit;
  assign claim_take   = rd && (addr == ADDR_CLAIM) && (state_q == ST_IDLE) && pend_valid;
  assign complete_hit = wr && (addr == ADDR_COMPLETE) && (state_q == ST_ACTIVE)
                        && (sa_dat_i[4:0] == active_id);

  // Pending update. For edge sources a new edge is ORed in last so it wins
  // over both an ICR clear and a claim in the same cycle. Level sources
  // simply follow the registered line gated by the enable mask.
  logic [INT_NUM-1:0] edge_set, icr_clr, claim_clr;
  assign edge_set  = int_q & ~int_prev & ier;
  assign icr_clr   = (wr && addr == ADDR_ICR) ? sa_dat_i[INT_NUM-1:0] : '0;
  assign claim_clr = claim_take ? (INT_NUM'(1) << pend_id) : '0;
  assign ipr_d     = (itr & (edge_set | (ipr & ~icr_clr & ~claim_clr)))
                   | (~itr & int_q & ier);

  // In-service register: one-hot of the claimed source while ACTIVE.
  logic [INT_NUM-1:0] isr_vec;
  assign isr_vec = (state_q == ST_ACTIVE) ? (INT_NUM'(1) << active_id) : '0;

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_MER: rd_data[1:0] = mer;
      ADDR_IER: rd_data[INT_NUM-1:0] = ier;
      ADDR_ITR: rd_data[INT_NUM-1:0] = itr;
      ADDR_IPR: rd_data[INT_NUM-1:0] = ipr;
      ADDR_CLAIM: begin
        if (state_q == ST_IDLE && pend_valid) rd_data[4:0] = pend_id;
        else                                  rd_data = Dw'(CLAIM_NONE);
      end
      ADDR_ISR: rd_data[INT_NUM-1:0] = isr_vec;
      default: rd_data = '0;
    endcase
  end

  // Claim/complete FSM: next state and interrupt output.
  always_comb begin
    state_d = state_q;
    int_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        int_o = (mer == 2'b11) && pend_valid;
        if (claim_take) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (complete_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign int_id_o  = pend_id;
  assign dbg_state = (state_q == ST_ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      active_id <= 5'd0;
      mer       <= 2'b00;
      ier       <= '0;
      itr       <= '0;
      ipr       <= '0;
      int_q     <= '0;
      int_prev  <= '0;
      sa_ack_o  <= 1'b0;
      sa_dat_o  <= '0;
    end else begin
      state_q  <= state_d;
      int_q    <= int_src;
      int_prev <= int_q;
      ipr      <= ipr_d;
      sa_ack_o <= access;
      if (access) sa_dat_o <= sa_we_i ? '0 : rd_data;
      if (claim_take) active_id <= pend_id;
      if (wr && addr == ADDR_MER) mer <= sa_dat_i[1:0];
      if (wr && addr == ADDR_IER) ier <= sa_dat_i[INT_NUM-1:0];
      if (wr && addr == ADDR_ITR) itr <= sa_dat_i[INT_NUM-1:0];
    end
  end

endmodule

// File: tb/tb_int_ctrl_pri.sv
// tb_int_ctrl_pri
// Directed bench for int_ctrl_pri (INT_NUM = 8). Bus reads/writes and
// interrupt pulses are driven on the falling edge; outputs are sampled on
// the falling edge after the rising edge that updates them.
module tb_int_ctrl_pri;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] sa_dat_i = '0;
  logic [3:0]  sa_sel_i = 4'hF;
  logic [2:0]  sa_addr_i = '0;
  logic        sa_stb_i = 1'b0;
  logic        sa_we_i = 1'b0;
  logic [31:0] sa_dat_o;
  logic        sa_ack_o, sa_err_o, sa_rty_o;
  logic [7:0]  int_i = '0;
  logic        int_o;
  logic [4:0]  int_id_o;
  logic        dbg_state;

  int n_cmp = 0;
  int n_err = 0;

`ifdef INT_CTRL_SYNC_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 2;
`endif

  int_ctrl_pri #(.INT_NUM(8), .Dw(32), .Aw(3), .SELw(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .sa_dat_i  (sa_dat_i),
    .sa_sel_i  (sa_sel_i),
    .sa_addr_i (sa_addr_i),
    .sa_stb_i  (sa_stb_i),
    .sa_we_i   (sa_we_i),
    .sa_dat_o  (sa_dat_o),
    .sa_ack_o  (sa_ack_o),
    .sa_err_o  (sa_err_o),
    .sa_rty_o  (sa_rty_o),
    .int_i     (int_i),
    .int_o     (int_o),
    .int_id_o  (int_id_o),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    sa_stb_i = 1'b1; sa_we_i = 1'b1; sa_addr_i = a; sa_dat_i = d;
    @(negedge clk);
    chk("wr_ack", {31'b0, sa_ack_o}, 32'd1);
    sa_stb_i = 1'b0; sa_we_i = 1'b0;
  endtask

  task automatic bus_rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    sa_stb_i = 1'b1; sa_we_i = 1'b0; sa_addr_i = a;
    @(negedge clk);
    chk({tag, "_ack"}, {31'b0, sa_ack_o}, 32'd1);
    chk(tag, sa_dat_o, exp);
    sa_stb_i = 1'b0;
  endtask

  // One-cycle pulse; returns on the falling edge after ipr has been updated.
  task automatic pulse(input logic [7:0] m);
    @(negedge clk); int_i = m;
    @(negedge clk); int_i = '0;
    @(negedge clk);
  endtask

  task automatic chk_int(input string tag, input logic o, input logic [4:0] id);
    chk({tag, "_int_o"}, {31'b0, int_o}, {31'b0, o});
    chk({tag, "_id"}, {27'b0, int_id_o}, {27'b0, id});
  endtask

  initial begin : main
    int lat;
    // Reset
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_int("rst", 1'b0, 5'd0);
    chk("rst_state", {31'b0, dbg_state}, 32'd0);
    chk("rst_err_rty", {30'b0, sa_err_o, sa_rty_o}, 32'd0);
    bus_rd("rst_mer", 3'd0, 32'h0);
    bus_rd("rst_ier", 3'd1, 32'h0);
    bus_rd("rst_itr", 3'd2, 32'h0);
    bus_rd("rst_icr", 3'd3, 32'h0);
    bus_rd("rst_ipr", 3'd4, 32'h0);
    bus_rd("rst_claim", 3'd5, 32'hFFFF_FFFF);
    bus_rd("rst_cmpl", 3'd6, 32'h0);
    bus_rd("rst_isr", 3'd7, 32'h0);

    // Configure: all enabled, all edge
    bus_wr(3'd0, 32'h3);
    bus_wr(3'd1, 32'hFFFF_FFFF);
    bus_wr(3'd2, 32'h0000_00FF);
    bus_rd("cfg_mer", 3'd0, 32'h3);
    bus_rd("cfg_ier", 3'd1, 32'hFF);
    bus_rd("cfg_itr", 3'd2, 32'hFF);

    // Single edge on source 5
    pulse(8'h20);
    chk_int("e5", 1'b1, 5'd5);
    bus_rd("e5_ipr", 3'd4, 32'h20);
    bus_rd("e5_claim", 3'd5, 32'd5);
    chk("e5_state", {31'b0, dbg_state}, 32'd1);
    chk_int("e5_act", 1'b0, 5'd0);
    bus_rd("e5_ipr2", 3'd4, 32'h0);
    bus_rd("e5_isr", 3'd7, 32'h20);
    bus_rd("e5_claim_act", 3'd5, 32'hFFFF_FFFF);
    bus_wr(3'd6, 32'd5);
    chk("e5_done", {31'b0, dbg_state}, 32'd0);
    chk_int("e5_idle", 1'b0, 5'd0);
    bus_rd("e5_isr2", 3'd7, 32'h0);

    // Simultaneous edges on 2 and 6
    pulse(8'h44);
    chk_int("e26", 1'b1, 5'd2);
    bus_rd("e26_ipr", 3'd4, 32'h44);
    bus_rd("e26_claim2", 3'd5, 32'd2);
    chk_int("e26_act", 1'b0, 5'd6);
    bus_rd("e26_claim_act", 3'd5, 32'hFFFF_FFFF);
    bus_wr(3'd6, 32'd2);
    chk_int("e26_next", 1'b1, 5'd6);
    bus_rd("e26_claim6", 3'd5, 32'd6);
    bus_wr(3'd6, 32'd6);
    chk_int("e26_done", 1'b0, 5'd0);

    // Level source 3
    bus_wr(3'd2, 32'h0);
    @(negedge clk); int_i = 8'h08;
    @(negedge clk);
    @(negedge clk);
    chk_int("l3", 1'b1, 5'd3);
    bus_rd("l3_ipr", 3'd4, 32'h08);
    bus_rd("l3_claim", 3'd5, 32'd3);
    chk_int("l3_act", 1'b0, 5'd3);
    bus_rd("l3_ipr_act", 3'd4, 32'h08);
    bus_wr(3'd6, 32'd3);
    chk_int("l3_cmpl", 1'b1, 5'd3);
    bus_wr(3'd3, 32'h08);
    bus_rd("l3_icr_noeff", 3'd4, 32'h08);
    bus_wr(3'd1, 32'hF7);
    chk_int("l3_masked", 1'b0, 5'd0);
    bus_wr(3'd1, 32'hFF);
    @(negedge clk);
    chk_int("l3_unmask", 1'b1, 5'd3);
    int_i = 8'h00;
    @(negedge clk);
    chk_int("l3_drop1", 1'b1, 5'd3);
    @(negedge clk);
    chk_int("l3_drop2", 1'b0, 5'd0);

    // Edge on source 1 together with an ICR clear of bit 1
    bus_wr(3'd2, 32'hFF);
    @(negedge clk); int_i = 8'h02;
    @(negedge clk); int_i = 8'h00;
    sa_stb_i = 1'b1; sa_we_i = 1'b1; sa_addr_i = 3'd3; sa_dat_i = 32'h02;
    @(negedge clk);
    sa_stb_i = 1'b0; sa_we_i = 1'b0;
    bus_rd("icr_race_ipr", 3'd4, 32'h02);
    bus_rd("icr_race_claim", 3'd5, 32'd1);
    bus_wr(3'd6, 32'd4);
    chk("bad_cmpl_state", {31'b0, dbg_state}, 32'd1);
    bus_rd("bad_cmpl_isr", 3'd7, 32'h02);
    bus_wr(3'd6, 32'd1);
    chk("good_cmpl_state", {31'b0, dbg_state}, 32'd0);

    // int_i to int_o latency, bounded wait
    @(negedge clk); int_i = 8'h01;
    lat = 0;
    while (!int_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, EXP_LAT);
    chk_int("lat_id", 1'b1, 5'd0);
    int_i = 8'h00;
    bus_rd("lat_claim", 3'd5, 32'd0);
    bus_wr(3'd6, 32'd0);

    // Reset while ACTIVE
    pulse(8'h80);
    bus_rd("r7_claim", 3'd5, 32'd7);
    chk("r7_state", {31'b0, dbg_state}, 32'd1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("r7_state_after", {31'b0, dbg_state}, 32'd0);
    chk_int("r7_int", 1'b0, 5'd0);
    chk("r7_ack", {31'b0, sa_ack_o}, 32'd0);
    chk("r7_dat", sa_dat_o, 32'h0);
    bus_rd("r7_mer", 3'd0, 32'h0);
    bus_rd("r7_ier", 3'd1, 32'h0);
    bus_rd("r7_itr", 3'd2, 32'h0);
    bus_rd("r7_ipr", 3'd4, 32'h0);
    bus_rd("r7_isr", 3'd7, 32'h0);
    bus_rd("r7_claim2", 3'd5, 32'hFFFF_FFFF);

    // Report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
